// File: rtl/loadstore_rs.sv
// loadstore_rs: in-order load/store reservation station with CDB snoop
// and a fixed-occupancy issue stage feeding the load/store unit.
module loadstore_rs #(
    parameter int DEPTH        = 4,
    parameter int TAG_W        = 4,
    parameter int ISSUE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic                   disp_op,
    input  logic [2:0]             disp_width,
    input  logic                   disp_base_rdy,
    input  logic [31:0]            disp_base,
    input  logic [TAG_W-1:0]       disp_base_tag,
    input  logic [31:0]            disp_imm,
    input  logic                   disp_src_rdy,
    input  logic [31:0]            disp_src,
    input  logic [TAG_W-1:0]       disp_src_tag,
    input  logic [4:0]             disp_rd,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [31:0]            cdb_data,
    output logic                   exec_enable,
    output logic [104:0]           exec_rs,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = ISSUE_CYCLES > 1 ? $clog2(ISSUE_CYCLES) : 1;

    typedef struct packed {
        logic             op;
        logic [2:0]       width;
        logic             base_rdy;
        logic [31:0]      base;
        logic [TAG_W-1:0] base_tag;
        logic [31:0]      imm;
        logic             src_rdy;
        logic [31:0]      src;
        logic [TAG_W-1:0] src_tag;
        logic [4:0]       rd;
    } ent_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    ent_t             ent_q [DEPTH];
    ent_t             eff   [DEPTH];
    ent_t             din;
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    head_q, tail_q, nxt;
    logic [CW-1:0]    count_q;
    state_t           state_q;
    logic [NW-1:0]    cnt_q;
    logic             exec_enable_q;
    logic [104:0]     exec_rs_q;
    logic             head_rdy, nxt_rdy, last, push, pop;

    // Loads never wait on store data, so their src field is left untouched.
    function automatic ent_t snoop(input ent_t e, input logic v, input logic [TAG_W-1:0] t,
                                   input logic [31:0] d);
        snoop = e;
        if (v && !e.base_rdy && e.base_tag == t) begin
            snoop.base_rdy = 1'b1;
            snoop.base     = d;
        end
        if (v && e.op && !e.src_rdy && e.src_tag == t) begin
            snoop.src_rdy = 1'b1;
            snoop.src     = d;
        end
    endfunction

    function automatic logic rdy(input ent_t e);
        return e.base_rdy && (!e.op || e.src_rdy);
    endfunction

    function automatic logic [104:0] pkt(input ent_t e);
        return {e.op, e.width, e.base, e.imm, e.src, e.rd};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            eff[i] = snoop(ent_q[i], cdb_valid, cdb_tag, cdb_data);
    end

    assign din = snoop(ent_t'{disp_op, disp_width, disp_base_rdy, disp_base, disp_base_tag,
                              disp_imm, disp_src_rdy, disp_src, disp_src_tag, disp_rd},
                       cdb_valid, cdb_tag, cdb_data);

    assign nxt         = head_q + PW'(1);
    assign head_rdy    = vld_q[head_q] && rdy(eff[head_q]);
    assign nxt_rdy     = vld_q[nxt] && rdy(eff[nxt]);
    assign last        = state_q == ISSUE && cnt_q == NW'(ISSUE_CYCLES - 1);
    assign disp_ready  = count_q < CW'(DEPTH);
    assign push        = disp_valid && disp_ready;
    assign pop         = last;
    assign count       = count_q;
    assign exec_enable = exec_enable_q;
    assign exec_rs     = exec_rs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            vld_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            exec_enable_q <= 1'b0;
            exec_rs_q     <= '0;
        end else if (flush) begin
            vld_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            exec_enable_q <= 1'b0;
            exec_rs_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= eff[i];
            if (push) begin
                ent_q[tail_q] <= din;
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= nxt;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            case (state_q)
                IDLE: if (head_rdy) begin
                    exec_rs_q     <= pkt(eff[head_q]);
                    exec_enable_q <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= ISSUE;
                end
                ISSUE: if (!last) begin
                    cnt_q <= cnt_q + NW'(1);
                end else if (nxt_rdy) begin
                    exec_rs_q <= pkt(eff[nxt]);
                    cnt_q     <= '0;
                end else begin
                    state_q       <= IDLE;
                    exec_enable_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/loadstore_rs.md
Name: loadstore_rs

Overview:
- In-order reservation station for memory ops, directly upstream of the load/store execution unit.
- Accepts dispatched load/store ops whose operands may still be pending (tagged), and snoops the common data bus (CDB) to capture results.
- Issues the oldest ready entry as a 105-bit packet, holding it stable with exec_enable for exactly 3 cycles, the execution unit's occupancy.
- Strict program order: no load/store reordering.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
TAG_W, 4, width of producer tags on operands and CDB
ISSUE_CYCLES, 3, cycles exec_enable/exec_rs are held per op

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries and any in-flight issue
disp_valid  in  1  dispatch request
disp_ready  out  1  space available; dispatch accepted when disp_valid&&disp_ready
disp_op  in  1  0=load, 1=store
disp_width  in  3  access width code, passed through
disp_base_rdy  in  1  base value present
disp_base  in  32  base value (if rdy) else don't-care
disp_base_tag  in  TAG_W  producer tag when !disp_base_rdy
disp_imm  in  32  sign-extended offset
disp_src_rdy  in  1  store data present (ignored for loads)
disp_src  in  32  store data
disp_src_tag  in  TAG_W  producer tag when !disp_src_rdy
disp_rd  in  5  load destination register (stores: 0)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  32  broadcast value
exec_enable  out  1  execution unit enable
exec_rs  out  105  {op, width[2:0], base[31:0], imm[31:0], src[31:0], rd[4:0]}, MSB first
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (reset_n low, async): all entries invalid, head=tail=0, count=0, FSM=IDLE, exec_enable=0, exec_rs=0, disp_ready=1.
- Storage: circular buffer, head/tail pointers wrap at DEPTH; count tracks occupancy (no pointer-equality ambiguity).
- disp_ready = (count < DEPTH); combinational from registered count only. A pop in the same cycle does not raise it.
- Dispatch: on accept, write entry at tail, tail++, count++. Dispatch with disp_valid while !disp_ready is dropped with no state change.
- CDB snoop, every cycle: for each valid entry with operand not ready and tag==cdb_tag while cdb_valid, capture cdb_data and set ready.
- Same-cycle dispatch: an operand dispatched not-ready whose tag matches the current CDB broadcast is stored as ready with cdb_data.
- Loads: src readiness ignored (treated ready).
- Head ready: entry valid && base ready && (op==load || src ready). Only the head is checked; younger ready entries wait.
- FSM, IDLE:
  - If head ready: register exec_rs from head, exec_enable=1 next cycle, cnt=0, go ISSUE.
- FSM, ISSUE:
  - exec_enable=1 and exec_rs held constant for ISSUE_CYCLES consecutive cycles; cnt increments each cycle.
  - On the last cycle, pop head (head++, count--).
  - If the next entry is ready in that same cycle (CDB bypass included), load it and stay in ISSUE with cnt=0, so exec_enable stays high back-to-back.
  - Otherwise go IDLE, exec_enable=0.
- Issue latency: a fully-ready op dispatched into an empty station at edge N drives exec_enable=1 from edge N+1 (one cycle in the entry).
- Simultaneous dispatch and pop: count unchanged, both pointers advance. Legal when full, but disp_ready remains 0 that cycle.
- flush: next edge all entries invalid, count=0, head=tail=0, FSM=IDLE, exec_enable=0. Flush overrides dispatch and CDB capture in the same cycle.
- Reset mid-issue: exec_enable falls immediately (async), and the entry is lost.
- Arithmetic: no address computation here. base/imm/src pass through unmodified; width is opaque.

Test Plan:
- Ready load (op0, width 3'b010, base 0x1000, imm 0x4, rd 5) into empty station -> exec_enable high 3 cycles starting 1 cycle after dispatch; exec_rs = {1'b0, 3'b010, 0x1000, 0x4, 0x0, 5'd5}; count returns 0.
- Store with src_rdy=0 tag 3; CDB tag 3 data 0xDEADBEEF two cycles later -> no issue before capture; exec_rs.src=0xDEADBEEF, issue starts the cycle after the broadcast.
- Dispatch load with base tag 7 in the same cycle as cdb_valid tag 7 data 0x2000 -> captured at dispatch; issued with base 0x2000.
- Fill 4 entries (head store not ready) -> disp_ready=0, fifth dispatch dropped, count=4. Release head via CDB -> 4 ops issue in order, exec_enable continuous for 12 cycles, pointers wrap correctly.
- Head not ready, entry 1 ready -> nothing issues (in-order). Assert flush mid-issue of a later op -> exec_enable 0 next cycle, count 0; new dispatch issues normally afterwards.
- Pulse reset_n low during ISSUE cycle 2 -> exec_enable and exec_rs go 0 asynchronously; count 0, disp_ready 1.
